// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants, position type and sync-polarity helpers for the VGA timing generator.
// The defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_gen_pkg;

  localparam int VGA_POS_W   = 10;
  localparam int VGA_POS_MAX = 1 << VGA_POS_W;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  typedef logic [VGA_POS_W-1:0] vga_pos_t;
  typedef logic [VGA_POS_W:0]   vga_pos_ext_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic display_on;
  } vga_ctrl_t;

  function automatic logic sync_level(input logic pol, input logic asserted);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap strobe plus sync/active decodes of the next position.
// Used once for columns (en = ce) and once for lines (en = column wrap).
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int DISPLAY = H_DISPLAY_DEF,
  parameter int FRONT   = H_FRONT_DEF,
  parameter int SYNC    = H_SYNC_DEF,
  parameter int BACK    = H_BACK_DEF
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     en,
  input  logic     clear,
  output vga_pos_t pos,
  output logic     wrap,
  output logic     sync_next,
  output logic     active_next
);

  localparam int TOTAL = DISPLAY + FRONT + SYNC + BACK;

  if (TOTAL > VGA_POS_MAX) begin : g_total_chk
    $error("vga_axis_counter: total %0d exceeds %0d positions", TOTAL, VGA_POS_MAX);
  end

  localparam vga_pos_t     LAST       = vga_pos_t'(TOTAL - 1);
  // Decode bounds are one bit wider so a boundary of exactly 1024 still compares correctly.
  localparam vga_pos_ext_t ACTIVE_END = vga_pos_ext_t'(DISPLAY);
  localparam vga_pos_ext_t SYNC_START = vga_pos_ext_t'(DISPLAY + FRONT);
  localparam vga_pos_ext_t SYNC_END   = vga_pos_ext_t'(DISPLAY + FRONT + SYNC);

  vga_pos_t     pos_next;
  vga_pos_ext_t pos_next_ext;

  assign wrap = en && (pos == LAST);

  always_comb begin
    pos_next = pos;
    if (clear || wrap) pos_next = '0;
    else if (en)       pos_next = pos + vga_pos_t'(1);
  end

  assign pos_next_ext = {1'b0, pos_next};
  assign sync_next    = (pos_next_ext >= SYNC_START) && (pos_next_ext < SYNC_END);
  assign active_next  = (pos_next_ext < ACTIVE_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pos <= '0;
    else       pos <= pos_next;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: sync, display enable and pixel coordinates with a pixel clock-enable.
// Define VGA_TIMING_FRAME_CNT_EN to get a live 12-bit frame counter; otherwise frame_cnt reads 0.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   H_DISPLAY = H_DISPLAY_DEF,
  parameter int   H_FRONT   = H_FRONT_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BACK    = H_BACK_DEF,
  parameter int   V_DISPLAY = V_DISPLAY_DEF,
  parameter int   V_FRONT   = V_FRONT_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BACK    = V_BACK_DEF,
  parameter logic SYNC_POL  = SYNC_ACTIVE_LOW
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  output logic        hsync,
  output logic        vsync,
  output logic        display_on,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        line_end,
  output logic        frame_end,
  output logic [11:0] frame_cnt
);

  logic      h_wrap, h_sync_nx, h_act_nx;
  logic      v_wrap, v_sync_nx, v_act_nx;
  vga_pos_t  h_pos, v_pos;
  vga_ctrl_t ctrl_d, ctrl_q;

  vga_axis_counter #(
    .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h (
    .clk(clk), .reset(reset), .en(ce), .clear(1'b0),
    .pos(h_pos), .wrap(h_wrap), .sync_next(h_sync_nx), .active_next(h_act_nx)
  );

  vga_axis_counter #(
    .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v (
    .clk(clk), .reset(reset), .en(h_wrap & ce), .clear(1'b0),
    .pos(v_pos), .wrap(v_wrap), .sync_next(v_sync_nx), .active_next(v_act_nx)
  );

  // Loaded from next-state decodes so the registered controls line up with hpos/vpos.
  always_comb begin
    ctrl_d.hsync      = sync_level(SYNC_POL, h_sync_nx);
    ctrl_d.vsync      = sync_level(SYNC_POL, v_sync_nx);
    ctrl_d.display_on = h_act_nx & v_act_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q.hsync      <= ~SYNC_POL;
      ctrl_q.vsync      <= ~SYNC_POL;
      ctrl_q.display_on <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign hsync      = ctrl_q.hsync;
  assign vsync      = ctrl_q.vsync;
  assign display_on = ctrl_q.display_on;
  assign hpos       = h_pos;
  assign vpos       = v_pos;
  assign line_end   = h_wrap;
  assign frame_end  = v_wrap;

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          frame_cnt <= '0;
    else if (frame_end) frame_cnt <= frame_cnt + 12'd1;
  end
`else
  assign frame_cnt = 12'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance for line-level timing and a tiny 16x12
// active-high-sync instance so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;

  logic        hsync, vsync, display_on, line_end, frame_end;
  logic [9:0]  hpos, vpos;
  logic [11:0] frame_cnt;

  logic        s_hsync, s_vsync, s_display_on, s_line_end, s_frame_end;
  logic [9:0]  s_hpos, s_vpos;
  logic [11:0] s_frame_cnt;

  int checks   = 0;
  int failures = 0;

  int le_prev, period, hold_bad, le_bad, le_cnt, lo_cnt, le_at;
  int vs_cnt, vs_bad, fe_cnt, fe_bad, fe_first, fe_period;
  logic [9:0] h0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut (
    .clk(clk), .reset(reset), .ce(ce),
    .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .hpos(hpos), .vpos(vpos), .line_end(line_end), .frame_end(frame_end),
    .frame_cnt(frame_cnt)
  );

  // 16 columns (sync 10..12), 12 lines (sync 8..9), sync asserted high.
  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .SYNC_POL(1'b1)
  ) u_small (
    .clk(clk), .reset(reset), .ce(ce),
    .hsync(s_hsync), .vsync(s_vsync), .display_on(s_display_on),
    .hpos(s_hpos), .vpos(s_vpos), .line_end(s_line_end), .frame_end(s_frame_end),
    .frame_cnt(s_frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ce    = 1'b1;

    // Reset held with ce=1
    run(5);
    chk("rst_hpos", hpos, 0);
    chk("rst_vpos", vpos, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_disp", display_on, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_line_end", line_end, 0);
    chk("rst_small_hsync", s_hsync, 0);

    // Free-run: horizontal boundaries on line 0
    reset = 1'b0;
    run(1);
    chk("h1_hpos", hpos, 1);
    chk("h1_disp", display_on, 1);
    run(638);
    chk("h639_disp", display_on, 1);
    run(1);
    chk("h640_hpos", hpos, 640);
    chk("h640_disp", display_on, 0);
    run(15);
    chk("h655_hsync", hsync, 1);
    run(1);
    chk("h656_hsync", hsync, 0);
    run(95);
    chk("h751_hsync", hsync, 0);
    run(1);
    chk("h752_hsync", hsync, 1);
    run(47);
    chk("h799_hpos", hpos, 799);
    chk("h799_line_end", line_end, 1);
    chk("h799_frame_end", frame_end, 0);
    run(1);
    chk("wrap_hpos", hpos, 0);
    chk("wrap_vpos", vpos, 1);
    chk("wrap_line_end", line_end, 0);
    chk("wrap_disp", display_on, 1);

    // One full line from (0,1): hsync low count and line_end position
    lo_cnt = 0; le_cnt = 0; le_at = -1;
    for (int i = 0; i < 800; i++) begin
      if (hsync == 1'b0) lo_cnt++;
      if (line_end) begin le_cnt++; le_at = i; end
      run(1);
    end
    chk("line_hsync_low", lo_cnt, 96);
    chk("line_le_cnt", le_cnt, 1);
    chk("line_le_at", le_at, 799);
    chk("line2_vpos", vpos, 2);
    chk("line2_hpos", hpos, 0);

    // Asynchronous reset mid-frame, between edges
    reset_pulse();
    run(1100);
    chk("pre_hpos", hpos, 300);
    chk("pre_vpos", vpos, 1);
    chk("pre_disp", display_on, 1);
    chk("pre_small_hsync", s_hsync, 1);
    chk("pre_small_vsync", s_vsync, 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_hpos", hpos, 0);
    chk("arst_vpos", vpos, 0);
    chk("arst_disp", display_on, 0);
    chk("arst_hsync", hsync, 1);
    chk("arst_small_hsync", s_hsync, 0);
    chk("arst_small_vsync", s_vsync, 0);
    chk("arst_small_hpos", s_hpos, 0);
    @(negedge clk);
    reset = 1'b0;
    run(5);
    chk("resume_hpos", hpos, 5);
    chk("resume_vpos", vpos, 0);

    // ce alternating 1/0
    reset_pulse();
    le_prev = -1; period = 0; hold_bad = 0; le_bad = 0; le_cnt = 0;
    for (int i = 0; i < 3400; i++) begin
      ce = (i % 2 == 0);
      #1;
      if (line_end) begin
        if (!ce) le_bad++;
        else begin
          if (le_prev >= 0 && period == 0) period = i - le_prev;
          le_prev = i;
          le_cnt++;
        end
      end
      h0 = hpos;
      @(negedge clk);
      if (!ce && hpos != h0) hold_bad++;
    end
    ce = 1'b1;
    chk("ce_hold_bad", hold_bad, 0);
    chk("ce_le_on_idle", le_bad, 0);
    chk("ce_le_cnt", le_cnt, 2);
    chk("ce_line_period", period, 1600);

    // Three frames on the small instance
    reset_pulse();
    vs_cnt = 0; vs_bad = 0; fe_cnt = 0; fe_bad = 0; fe_first = -1; fe_period = 0;
    for (int i = 0; i < 576; i++) begin
      if (s_vsync) begin
        vs_cnt++;
        if (s_vpos < 8 || s_vpos > 9) vs_bad++;
      end
      if (s_frame_end) begin
        fe_cnt++;
        if (s_hpos != 15 || s_vpos != 11) fe_bad++;
        if (fe_first < 0) fe_first = i;
        else if (fe_period == 0) fe_period = i - fe_first;
      end
      run(1);
    end
    chk("frm_vsync_cnt", vs_cnt, 96);
    chk("frm_vsync_rows", vs_bad, 0);
    chk("frm_fe_cnt", fe_cnt, 3);
    chk("frm_fe_pos", fe_bad, 0);
    chk("frm_fe_first", fe_first, 191);
    chk("frm_period", fe_period, 192);
    chk("frm_end_hpos", s_hpos, 0);
    chk("frm_end_vpos", s_vpos, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("frm_cnt", s_frame_cnt, 3);
`else
    chk("frm_cnt", s_frame_cnt, 0);
`endif
    chk("frm_cnt_big", frame_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
